// File: rtl/pc_pkg.sv
// Shared types for the program-counter unit: redirect-source encoding and RAS sizing.
// Imported by pc_unit and pc_ras.
package pc_pkg;

    // Winning redirect source for a cycle, as chosen by the priority encoder.
    typedef enum logic [2:0] {
        SEQ,
        BRANCH,
        JUMP,
        CALL,
        RET,
        HOLD
    } redirect_t;

    // Pointer width for a RAS of the given depth (depth is a power of two >= 2).
    function automatic int ras_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int RAS_DEPTH_DEFAULT = 4;
    localparam int RAS_PTR_W_DEFAULT = ras_ptr_w(RAS_DEPTH_DEFAULT);

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a push on a full stack overwrites the oldest entry.
// Single-cycle push/pop; overflow/underflow are registered one-cycle pulses.
module pc_ras
    import pc_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int RAS_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic                          pop,
    input  logic [WIDTH-1:0]              push_data,
    output logic [WIDTH-1:0]              top,
    output logic [ras_ptr_w(RAS_DEPTH):0] count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int PTR_W = ras_ptr_w(RAS_DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(RAS_DEPTH);

    logic [WIDTH-1:0] mem [RAS_DEPTH];
    logic [PTR_W-1:0] top_ptr;
    logic [PTR_W-1:0] push_ptr;
    logic             full;
    logic             empty;

    assign push_ptr = top_ptr + 1'b1;
    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign top      = mem[top_ptr];

    // Pointer wraps freely, so the newest RAS_DEPTH entries always survive an overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            top_ptr   <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= push && full;
            underflow <= pop && !push && empty;
            if (push) begin
                top_ptr <= push_ptr;
                if (!full) begin
                    count <= count + 1'b1;
                end
            end else if (pop && !empty) begin
                top_ptr <= top_ptr - 1'b1;
                count   <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[push_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter with stall, branch, jump and call/return redirects.
// pc_next is combinational; pc, RAS state and the RAS pulses update on the next clk edge.
module pc_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               STEP      = 1,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int               RAS_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        stall,
    input  logic                        branch_taken,
    input  logic [WIDTH-1:0]            branch_offset,
    input  logic                        jump,
    input  logic                        call,
    input  logic                        ret,
    input  logic [WIDTH-1:0]            jump_target,
    output logic [WIDTH-1:0]            pc,
    output logic [WIDTH-1:0]            pc_next,
    output logic [$clog2(RAS_DEPTH):0]  ras_count,
    output logic                        ras_overflow,
    output logic                        ras_underflow
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    redirect_t        source;
    logic [WIDTH-1:0] pc_seq;
    logic [WIDTH-1:0] pc_branch;
    logic [WIDTH-1:0] ras_top;
    logic             ras_push;
    logic             ras_pop;

    always_comb begin
        source = SEQ;
        if (stall) begin
            source = HOLD;
        end else if (ret) begin
            source = RET;
        end else if (call) begin
            source = CALL;
        end else if (jump) begin
            source = JUMP;
        end else if (branch_taken) begin
            source = BRANCH;
        end
    end

    // Adding the raw offset bits is two's-complement addition modulo 2^WIDTH.
    assign pc_seq    = pc + STEP_W;
    assign pc_branch = pc + branch_offset;

    always_comb begin
        pc_next = pc_seq;
        case (source)
            HOLD:       pc_next = pc;
            RET:        pc_next = (ras_count != '0) ? ras_top : pc_seq;
            CALL, JUMP: pc_next = jump_target;
            BRANCH:     pc_next = pc_branch;
            default:    pc_next = pc_seq;
        endcase
    end

    assign ras_push = (source == CALL);
    assign ras_pop  = (source == RET);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_VEC;
        end else begin
            pc <= pc_next;
        end
    end

    pc_ras #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_seq),
        .top       (ras_top),
        .count     (ras_count),
        .overflow  (ras_overflow),
        .underflow (ras_underflow)
    );

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: the driver queues the expected post-edge state for each vector,
// and an independent monitor pops and compares after every rising edge.
module tb_pc_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       stall = 1'b0;
    logic       branch_taken = 1'b0;
    logic [7:0] branch_offset = 8'h00;
    logic       jump = 1'b0;
    logic       call = 1'b0;
    logic       ret = 1'b0;
    logic [7:0] jump_target = 8'h00;
    logic [7:0] pc;
    logic [7:0] pc_next;
    logic [2:0] ras_count;
    logic       ras_overflow;
    logic       ras_underflow;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      name;
        logic [7:0] pc;
        logic [2:0] cnt;
        logic       ovf;
        logic       unf;
    } exp_t;

    exp_t exp_q[$];

    pc_unit #(
        .WIDTH     (8),
        .STEP      (1),
        .RESET_VEC (8'h10),
        .RAS_DEPTH (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .call          (call),
        .ret           (ret),
        .jump_target   (jump_target),
        .pc            (pc),
        .pc_next       (pc_next),
        .ras_count     (ras_count),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one vector at a falling edge and queue what must be visible after the next rising edge.
    task automatic step(input string name, input logic st, input logic r, input logic c,
                        input logic j, input logic b, input logic [7:0] off, input logic [7:0] tgt,
                        input logic [7:0] e_pc, input logic [2:0] e_cnt, input logic e_ovf,
                        input logic e_unf);
        exp_t e;
        stall         = st;
        ret           = r;
        call          = c;
        jump          = j;
        branch_taken  = b;
        branch_offset = off;
        jump_target   = tgt;
        e.name = name;
        e.pc   = e_pc;
        e.cnt  = e_cnt;
        e.ovf  = e_ovf;
        e.unf  = e_unf;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input string name, input logic [7:0] e_pc, input logic [2:0] e_cnt);
        step(name, 0, 0, 0, 0, 0, 8'h00, 8'h00, e_pc, e_cnt, 0, 0);
    endtask

    task automatic go(input string name, input logic [7:0] tgt, input logic [7:0] e_pc,
                      input logic [2:0] e_cnt);
        step(name, 0, 0, 0, 1, 0, 8'h00, tgt, e_pc, e_cnt, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.name, ".pc"}, int'(pc), int'(e.pc));
                check({e.name, ".cnt"}, int'(ras_count), int'(e.cnt));
                check({e.name, ".ovf"}, int'(ras_overflow), int'(e.ovf));
                check({e.name, ".unf"}, int'(ras_underflow), int'(e.unf));
            end
        end
    end

    initial begin : driver
        @(negedge clk);
        @(negedge clk);
        check("reset.pc", int'(pc), 'h10);
        check("reset.cnt", int'(ras_count), 0);
        check("reset.ovf", int'(ras_overflow), 0);
        check("reset.unf", int'(ras_underflow), 0);
        reset = 1'b0;

        idle("seq1", 8'h11, 3'd0);
        idle("seq2", 8'h12, 3'd0);
        idle("seq3", 8'h13, 3'd0);

        // Asynchronous reset in the low phase, well before the next rising edge.
        #2 reset = 1'b1;
        #1 check("async_reset.pc", int'(pc), 'h10);
        @(negedge clk);
        reset = 1'b0;
        idle("post_reset", 8'h11, 3'd0);

        go("jump_ff", 8'hFF, 8'hFF, 3'd0);
        idle("wrap", 8'h00, 3'd0);
        go("jump_05", 8'h05, 8'h05, 3'd0);
        step("branch_neg", 0, 0, 0, 0, 1, 8'hFE, 8'h00, 8'h03, 3'd0, 0, 0);
        go("jump_f0", 8'hF0, 8'hF0, 3'd0);
        step("branch_wrap", 0, 0, 0, 0, 1, 8'h20, 8'h00, 8'h10, 3'd0, 0, 0);

        step("stall_jump", 1, 0, 0, 1, 0, 8'h00, 8'h40, 8'h10, 3'd0, 0, 0);
        go("jump_40", 8'h40, 8'h40, 3'd0);

        go("jump_20", 8'h20, 8'h20, 3'd0);
        step("call_prio", 0, 0, 1, 1, 1, 8'h05, 8'h80, 8'h80, 3'd1, 0, 0);
        step("ret_call", 0, 1, 1, 0, 0, 8'h00, 8'h55, 8'h21, 3'd0, 0, 0);

        go("jump_01", 8'h01, 8'h01, 3'd0);
        step("call1", 0, 0, 1, 0, 0, 8'h00, 8'h11, 8'h11, 3'd1, 0, 0);
        step("call2", 0, 0, 1, 0, 0, 8'h00, 8'h21, 8'h21, 3'd2, 0, 0);
        step("call3", 0, 0, 1, 0, 0, 8'h00, 8'h31, 8'h31, 3'd3, 0, 0);
        step("call4", 0, 0, 1, 0, 0, 8'h00, 8'h41, 8'h41, 3'd4, 0, 0);
        step("call5_ovf", 0, 0, 1, 0, 0, 8'h00, 8'h50, 8'h50, 3'd4, 1, 0);
        step("stall_ret", 1, 1, 0, 0, 0, 8'h00, 8'h00, 8'h50, 3'd4, 0, 0);
        step("ret1", 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h42, 3'd3, 0, 0);
        step("ret2", 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h32, 3'd2, 0, 0);
        step("ret3", 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h22, 3'd1, 0, 0);
        step("ret4", 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h12, 3'd0, 0, 0);

        go("jump_30", 8'h30, 8'h30, 3'd0);
        step("ret_empty", 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h31, 3'd0, 0, 1);
        idle("unf_clear", 8'h32, 3'd0);

        step("call_b2b", 0, 0, 1, 0, 0, 8'h00, 8'h70, 8'h70, 3'd1, 0, 0);
        step("ret_b2b", 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h33, 3'd0, 0, 0);
        idle("tail", 8'h34, 3'd0);

        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
